// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: falling-obstacle slot pool with frame-based advance, LFSR-placed spawns and hit retirement
module obstacle_scheduler #(
  parameter int         NUM_SLOTS      = 4,
  parameter int         SPAWN_INTERVAL = 60,
  parameter int         STEP           = 4,
  parameter int         SCREEN_W       = 640,
  parameter int         SCREEN_H       = 480,
  parameter int         OBS_W          = 32,
  parameter logic [9:0] LFSR_SEED      = 10'h1A5
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    enable,
  input  logic                    hit_valid,
  input  logic [2:0]              hit_slot,
  output logic [NUM_SLOTS-1:0]    obs_active,
  output logic [10*NUM_SLOTS-1:0] obs_x_flat,
  output logic [10*NUM_SLOTS-1:0] obs_y_flat,
  output logic                    busy,
  output logic                    spawn_pulse,
  output logic [15:0]             dodged_count,
  output logic                    overrun
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(SPAWN_INTERVAL + 1);
  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, spawn_slot_q, spawn_slot_d, lowest, hs;
  logic                 busy_q, busy_d, spawn_pulse_q, spawn_pulse_d, overrun_q, overrun_d, dodge, last;
  logic [NUM_SLOTS-1:0] active_q, active_d, free;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  logic [15:0]          dodged_q, dodged_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [9:0]           lfsr_q, lfsr_d, x_map;
  logic [10:0]          sum;
  assign hs    = hit_slot[IW-1:0];
  assign last  = idx_q == IW'(NUM_SLOTS - 1);
  assign x_map = lfsr_q < 10'(SCREEN_W - OBS_W) ? lfsr_q : lfsr_q - 10'd416;
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    busy_d        = busy_q;
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    spawn_pulse_d = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    overrun_d     = overrun_q | (frame_tick & enable & busy_q);
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    dodge         = 1'b0;
    free          = '0;
    lowest        = '0;
    sum           = {1'b0, y_q[idx_q]} + 11'(STEP);
    case (state_q)
      IDLE: if (frame_tick && enable) begin
        state_d = UPDATE;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
      UPDATE: begin
        if (active_q[idx_q]) begin
          if (sum >= 11'(SCREEN_H)) begin
            active_d[idx_q] = 1'b0;
            y_d[idx_q]      = '0;
            dodge           = 1'b1;
          end else y_d[idx_q] = sum[9:0];
        end
        state_d = last ? SPAWN : UPDATE;
        idx_d   = last ? idx_q : idx_q + 1'b1;
      end
      SPAWN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // A hit overrides the same-cycle move, so a slot hit on its way off-screen is not counted as dodged
    if (hit_valid && 32'(hit_slot) < NUM_SLOTS) begin
      active_d[hs] = 1'b0;
      y_d[hs]      = '0;
      if (state_q == UPDATE && hs == idx_q) dodge = 1'b0;
    end
    if (state_q == SPAWN) begin
      if (spawn_pulse_q) begin
        active_d[spawn_slot_q] = 1'b1;
        y_d[spawn_slot_q]      = '0;
        x_d[spawn_slot_q]      = x_map;
        lfsr_d                 = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        cnt_d                  = CW'(SPAWN_INTERVAL - 1);
      end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
    // Spawn is decided on the last move so spawn_pulse lands in the SPAWN cycle; it sees this frame's retirements
    if (state_q == UPDATE && last) begin
      free = ~active_d;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) if (free[i]) lowest = IW'(i);
      spawn_pulse_d = (cnt_q == '0) && (|free);
      spawn_slot_d  = lowest;
    end
    dodged_d = (dodge && dodged_q != 16'hFFFF) ? dodged_q + 16'd1 : dodged_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      active_q      <= '0;
      spawn_pulse_q <= 1'b0;
      spawn_slot_q  <= '0;
      overrun_q     <= 1'b0;
      dodged_q      <= '0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      active_q      <= active_d;
      spawn_pulse_q <= spawn_pulse_d;
      spawn_slot_q  <= spawn_slot_d;
      overrun_q     <= overrun_d;
      dodged_q      <= dodged_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end
  assign obs_active   = active_q;
  assign busy         = busy_q;
  assign spawn_pulse  = spawn_pulse_q;
  assign dodged_count = dodged_q;
  assign overrun      = overrun_q;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign obs_x_flat[10*g +: 10] = x_q[g];
    assign obs_y_flat[10*g +: 10] = y_q[g];
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed frame-level checks of spawning, movement, retirement, hits and overrun
module tb_obstacle_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1, frame_tick = 1'b0, enable = 1'b1, hit_valid = 1'b0;
  logic [2:0]  hit_slot = '0;
  logic [3:0]  obs_active;
  logic [39:0] obs_x_flat, obs_y_flat;
  logic        busy, spawn_pulse, overrun;
  logic [15:0] dodged_count;
  int checks = 0, errors = 0, bcyc, spn, nspawn;
  typedef struct {int exp_spawn; logic [3:0] exp_act; int exp_y0;} vec_t;
  vec_t tbl[9];
  always #10 clk = ~clk;
  obstacle_scheduler #(.SPAWN_INTERVAL(4)) dut (
    .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .obs_active(obs_active),
    .obs_x_flat(obs_x_flat), .obs_y_flat(obs_y_flat), .busy(busy),
    .spawn_pulse(spawn_pulse), .dodged_count(dodged_count), .overrun(overrun));
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic int xs(input int s);
    return int'(obs_x_flat[10*s +: 10]);
  endfunction
  function automatic int ys(input int s);
    return int'(obs_y_flat[10*s +: 10]);
  endfunction
  task automatic frame(input int hit_cyc, input int hs, input int tick_cyc);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bcyc = 0;
    spn = 0;
    while (busy && bcyc < 20) begin
      bcyc++;
      if (spawn_pulse) spn = bcyc;
      hit_valid  = (bcyc == hit_cyc);
      hit_slot   = 3'(hs);
      frame_tick = (bcyc == tick_cyc);
      @(negedge clk);
    end
    hit_valid  = 1'b0;
    frame_tick = 1'b0;
    if (bcyc >= 20) begin
      checks++;
      errors++;
      $display("FAIL busy_bound actual=%0d expected=5", bcyc);
    end
    if (spn != 0) nspawn++;
  endtask
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0);
  endtask
  initial begin
    tbl[0] = '{1, 4'b0001, 0};  tbl[1] = '{0, 4'b0001, 4};  tbl[2] = '{0, 4'b0001, 8};
    tbl[3] = '{0, 4'b0001, 12}; tbl[4] = '{1, 4'b0011, 16}; tbl[5] = '{0, 4'b0011, 20};
    tbl[6] = '{0, 4'b0011, 24}; tbl[7] = '{0, 4'b0011, 28}; tbl[8] = '{1, 4'b0111, 32};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_active", obs_active, 0);
    chk("rst_x", obs_x_flat, 0);
    chk("rst_y", obs_y_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spawn", spawn_pulse, 0);
    chk("rst_dodged", dodged_count, 0);
    chk("rst_overrun", overrun, 0);
    for (int f = 0; f < 9; f++) begin
      frame(0, 0, 0);
      chk($sformatf("f%0d_busy_len", f + 1), bcyc, 5);
      chk($sformatf("f%0d_spawn_cyc", f + 1), spn, tbl[f].exp_spawn ? 5 : 0);
      chk($sformatf("f%0d_active", f + 1), obs_active, tbl[f].exp_act);
      chk($sformatf("f%0d_y0", f + 1), ys(0), tbl[f].exp_y0);
    end
    chk("x0", xs(0), 421);
    chk("x1", xs(1), 426);
    chk("x2", xs(2), 244);
    chk("y1_f9", ys(1), 16);
    run_frames(3);
    frame(0, 0, 0);
    chk("f13_spawn", spn, 5);
    chk("f13_x3", xs(3), 297);
    chk("f13_active", obs_active, 4'b1111);
    run_frames(3);
    frame(0, 0, 0);
    chk("f17_deferred", spn, 0);
    chk("f17_active", obs_active, 4'b1111);
    hit_valid = 1'b1;
    hit_slot  = 3'd2;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hit2_active", obs_active, 4'b1011);
    chk("hit2_y2", ys(2), 0);
    chk("hit2_dodged", dodged_count, 0);
    frame(0, 0, 0);
    chk("f18_spawn", spn, 5);
    chk("f18_x2", xs(2), 594);
    chk("f18_active", obs_active, 4'b1111);
    nspawn = 0;
    run_frames(102);
    chk("f19_120_spawns", nspawn, 0);
    chk("f120_y0", ys(0), 476);
    chk("f120_dodged", dodged_count, 0);
    frame(0, 0, 0);
    chk("f121_dodged", dodged_count, 1);
    chk("f121_spawn", spn, 5);
    chk("f121_x0", xs(0), 164);
    chk("f121_y0", ys(0), 0);
    chk("f121_active", obs_active, 4'b1111);
    run_frames(3);
    chk("f124_y1", ys(1), 476);
    frame(2, 1, 0);
    chk("f125_dodged", dodged_count, 1);
    chk("f125_spawn", spn, 5);
    chk("f125_x1", xs(1), 328);
    chk("f125_y1", ys(1), 0);
    frame(0, 0, 2);
    chk("f126_busy_len", bcyc, 5);
    chk("f126_overrun", overrun, 1);
    chk("f126_y3", ys(3), 452);
    @(negedge clk);
    chk("f126_no_extra", busy, 0);
    hit_valid = 1'b1;
    hit_slot  = 3'd5;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("hit5_ignored", obs_active, 4'b1111);
    enable = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("disabled_busy", busy, 0);
    @(negedge clk);
    chk("disabled_y3", ys(3), 452);
    enable = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_active", obs_active, 0);
    chk("mid_rst_x", obs_x_flat, 0);
    chk("mid_rst_y", obs_y_flat, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dodged", dodged_count, 0);
    chk("mid_rst_overrun", overrun, 0);
    frame(0, 0, 0);
    chk("post_rst_spawn", spn, 5);
    chk("post_rst_x0", xs(0), 421);
    chk("post_rst_active", obs_active, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
